// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the uart_word_tx transmit bridge.
package uart_word_tx_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, GUARD, WAIT} tx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

  // Width of the byte index within a word, with a 1-bit floor for 8-bit words.
  function automatic int byte_idx_w(input int word_w);
    return (word_w > 8) ? $clog2(word_w / 8) : 1;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Core-side push handshake of uart_word_tx.
interface uart_word_tx_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] core_data;
  logic              core_data_ready;
  logic              core_ready;

  modport master (output core_data, output core_data_ready, input core_ready);
  modport slave  (input core_data, input core_data_ready, output core_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 byte transmitter; one bit lasts 2*CLK_PER_HALF_BIT clocks, busy registers one cycle after start.
module uart_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 260
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_txd
);
  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic          r_busy;
  logic [9:0]    r_shift;
  logic [CW-1:0] r_baud;
  logic [3:0]    r_bit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy  <= 1'b0;
      r_shift <= '1;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy  <= 1'b1;
        r_shift <= {1'b1, i_data, 1'b0};
        r_baud  <= '0;
        r_bit   <= '0;
      end
    end else if (r_baud == CW'(BIT_CYC - 1)) begin
      r_baud  <= '0;
      r_shift <= {1'b1, r_shift[9:1]};
      if (r_bit == 4'd9) r_busy <= 1'b0;
      else               r_bit  <= r_bit + 1'b1;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_txd  = r_busy ? r_shift[0] : UART_IDLE_LVL;
endmodule

// File: rtl/uart_word_fifo.sv
// Synchronous WORD_W x DEPTH FIFO with extra-MSB pointers and a one-cycle flush.
module uart_word_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_wr_en,
  input  logic [WORD_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_flush,
  output logic [WORD_W-1:0]        o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push    = i_wr_en & ~o_full;

  // NOTE: storage is deliberately not reset so it maps onto RAM; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_flush)                 r_rd_ptr <= r_wr_ptr;
      else if (i_rd_en & ~o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_word_tx.sv
// Word-to-UART transmit bridge: FIFO-buffered words serialised into bytes for uart_tx.
// Optional UART_WORD_TX_FLUSH_EN adds flush_req, which discards queued words between words.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 260,
  parameter int WORD_W           = 32,
  parameter int DEPTH            = 64,
  parameter bit LSB_FIRST        = 1'b1
) (
  input  logic           clk,
  input  logic           rstn,
  uart_word_tx_if.slave  core,
`ifdef UART_WORD_TX_FLUSH_EN
  input  logic           flush_req,
`endif
  output logic           txd,
  output logic           busy,
  output logic           overflow
);
  localparam int NB  = WORD_W / 8;
  localparam int BIW = byte_idx_w(WORD_W);

  tx_state_t             r_state, w_state_n;
  logic [WORD_W-1:0]     r_word;
  logic [BIW-1:0]        r_b;
  logic [BIW-1:0]        w_sel;
  logic                  r_overflow;
  logic                  w_pop, w_tx_start, w_flush, w_flush_now, w_last;
  logic                  w_full, w_empty, w_tx_busy;
  logic [WORD_W-1:0]     w_head;
  logic [7:0]            w_tx_data;
  logic [$clog2(DEPTH):0] w_count;

  uart_word_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (core.core_data_ready),
    .i_wr_data (core.core_data),
    .i_rd_en   (w_pop),
    .i_flush   (w_flush),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

`ifdef UART_WORD_TX_FLUSH_EN
  logic r_flush_pend;

  // A flush seen mid-word is held until the word finishes and the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                r_flush_pend <= 1'b0;
    else if (r_state == IDLE) r_flush_pend <= 1'b0;
    else if (flush_req)       r_flush_pend <= 1'b1;
  end

  assign w_flush_now = flush_req | r_flush_pend;
`else
  assign w_flush_now = 1'b0;
`endif

  assign w_last    = (r_b == BIW'(NB - 1));
  assign w_sel     = LSB_FIRST ? r_b : BIW'(NB - 1) - r_b;
  assign w_tx_data = r_word[{w_sel, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_b        <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_pop) begin
        r_word <= w_head;
        r_b    <= '0;
      end else if (r_state == WAIT && !w_tx_busy && !w_last) begin
        r_b <= r_b + 1'b1;
      end
      if (core.core_data_ready && w_full) r_overflow <= 1'b1;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_state_n  = r_state;
    w_pop      = 1'b0;
    w_tx_start = 1'b0;
    w_flush    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_flush_now) begin
          w_flush = 1'b1;
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_n = LOAD;
        end
      end
      LOAD:  if (!w_tx_busy) w_state_n = START;
      START: begin
        w_tx_start = 1'b1;
        w_state_n  = GUARD;
      end
      GUARD: w_state_n = WAIT;
      WAIT:  if (!w_tx_busy) w_state_n = w_last ? IDLE : LOAD;
      default: w_state_n = IDLE;
    endcase
  end

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk     (clk),
    .rstn    (rstn),
    .i_start (w_tx_start),
    .i_data  (w_tx_data),
    .o_busy  (w_tx_busy),
    .o_txd   (txd)
  );

  assign core.core_ready = ~w_full;
  assign busy            = (w_count != '0) || (r_state != IDLE);
  assign overflow        = r_overflow;
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: decodes txd back into bytes and compares against hand-built words.
module tb_uart_word_tx;
  localparam int H = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_word_tx_if #(.WORD_W(W)) if_a ();
  uart_word_tx_if #(.WORD_W(W)) if_b ();

  logic txd_a, busy_a, ovf_a;
  logic txd_b, busy_b, ovf_b;
  logic sel;
  logic rx_line;
`ifdef UART_WORD_TX_FLUSH_EN
  logic flush_a, flush_b;
`endif

  uart_word_tx #(.CLK_PER_HALF_BIT(H), .WORD_W(W), .DEPTH(64), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rstn(rstn), .core(if_a),
`ifdef UART_WORD_TX_FLUSH_EN
    .flush_req(flush_a),
`endif
    .txd(txd_a), .busy(busy_a), .overflow(ovf_a)
  );

  uart_word_tx #(.CLK_PER_HALF_BIT(H), .WORD_W(W), .DEPTH(4), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rstn(rstn), .core(if_b),
`ifdef UART_WORD_TX_FLUSH_EN
    .flush_req(flush_b),
`endif
    .txd(txd_b), .busy(busy_b), .overflow(ovf_b)
  );

  assign rx_line = sel ? txd_b : txd_a;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  // Line receiver: mid-bit sampling; frames overlapping a reset are discarded.
  initial begin : rx
    logic [7:0] rx_b;
    bit         ab;
    rx_b = '0;
    forever begin
      @(negedge clk);
      if (rstn && rx_line == 1'b0) begin
        ab = 1'b0;
        repeat (H) begin @(negedge clk); if (!rstn) ab = 1'b1; end
        for (int i = 0; i < 8; i++) begin
          repeat (2 * H) begin @(negedge clk); if (!rstn) ab = 1'b1; end
          rx_b[i] = rx_line;
        end
        repeat (2 * H) begin @(negedge clk); if (!rstn) ab = 1'b1; end
        if (!ab && rx_line) rx_q.push_back(rx_b);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] w, input logic exp_rdy);
    check("core_ready_a", {63'd0, if_a.core_ready}, {63'd0, exp_rdy});
    if_a.core_data       = w;
    if_a.core_data_ready = 1'b1;
    @(negedge clk);
    if_a.core_data_ready = 1'b0;
  endtask

  task automatic exp_word(input logic [31:0] w, input logic lsb);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(lsb ? w[i*8 +: 8] : w[(3-i)*8 +: 8]);
  endtask

  task automatic wait_idle(input logic which, input int budget);
    int n;
    n = 0;
    while (((which ? busy_b : busy_a) !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_idle", {63'd0, (which ? busy_b : busy_a)}, 64'd0);
  endtask

  task automatic wait_bytes(input int cnt, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rx_started", 64'(rx_q.size() >= cnt), 64'd1);
  endtask

  task automatic cmp_bytes(input string tag);
    logic [7:0] got;
    check($sformatf("%s_count", tag), 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {56'd0, got}, {56'd0, exp_q[i]});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    if_a.core_data = '0; if_a.core_data_ready = 1'b0;
    if_b.core_data = '0; if_b.core_data_ready = 1'b0;
    sel = 1'b0;
`ifdef UART_WORD_TX_FLUSH_EN
    flush_a = 1'b0; flush_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    check("rst_txd",      {63'd0, txd_a},           64'd1);
    check("rst_busy",     {63'd0, busy_a},          64'd0);
    check("rst_overflow", {63'd0, ovf_a},           64'd0);
    check("rst_ready",    {63'd0, if_a.core_ready}, 64'd1);

    // One word, LSB first.
    push_a(32'hA1B2C3D4, 1'b1);
    check("busy_after_push", {63'd0, busy_a}, 64'd1);
    exp_word(32'hA1B2C3D4, 1'b1);
    wait_idle(1'b0, 2000);
    cmp_bytes("lsb_word");

    // Same word through the MSB-first instance.
    sel = 1'b1;
    @(negedge clk);
    check("core_ready_b", {63'd0, if_b.core_ready}, 64'd1);
    if_b.core_data = 32'hA1B2C3D4; if_b.core_data_ready = 1'b1;
    @(negedge clk);
    if_b.core_data_ready = 1'b0;
    exp_word(32'hA1B2C3D4, 1'b0);
    wait_idle(1'b1, 2000);
    cmp_bytes("msb_word");
    sel = 1'b0;
    @(negedge clk);

    // 64 back-to-back words: bytes run 0..255; one word drains early so the FIFO never fills.
    for (int i = 0; i < 64; i++) begin
      w = 32'h03020100 + 32'(i) * 32'h04040404;
      push_a(w, 1'b1);
      exp_word(w, 1'b1);
    end
    wait_idle(1'b0, 40000);
    cmp_bytes("burst64");

    // 65 pushes fill the FIFO (one word already popped); the next push is dropped.
    for (int i = 0; i < 65; i++) begin
      w = ~(32'h03020100 + 32'(i) * 32'h04040404);
      push_a(w, 1'b1);
      exp_word(w, 1'b1);
    end
    check("full_ready_low", {63'd0, if_a.core_ready}, 64'd0);
    push_a(32'hDEADBEEF, 1'b0);
    check("overflow_set", {63'd0, ovf_a}, 64'd1);
    wait_idle(1'b0, 40000);
    cmp_bytes("fill_drop");
    check("overflow_sticky", {63'd0, ovf_a},           64'd1);
    check("ready_after",     {63'd0, if_a.core_ready}, 64'd1);

    // Reset in the middle of the second byte.
    push_a(32'hA1B2C3D4, 1'b1);
    wait_bytes(1, 2000);
    repeat (6 * H) @(negedge clk);
    #1 rstn = 1'b0;
    #1 check("txd_in_reset", {63'd0, txd_a}, 64'd1);
    rx_q.delete();
    repeat (20) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_rst_txd",      {63'd0, txd_a},           64'd1);
    check("post_rst_busy",     {63'd0, busy_a},          64'd0);
    check("post_rst_overflow", {63'd0, ovf_a},           64'd0);
    check("post_rst_ready",    {63'd0, if_a.core_ready}, 64'd1);
    repeat (200) @(negedge clk);
    check("no_residual_bytes", 64'(rx_q.size()), 64'd0);
    check("idle_line",         {63'd0, txd_a},   64'd1);

`ifdef UART_WORD_TX_FLUSH_EN
    // Flush during word 1: word 1 completes, words 2-5 are discarded.
    for (int i = 0; i < 5; i++) push_a(32'h11223344 + 32'(i), 1'b1);
    exp_word(32'h11223344, 1'b1);
    wait_bytes(1, 2000);
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    wait_idle(1'b0, 5000);
    repeat (100) @(negedge clk);
    cmp_bytes("flush");
    check("flush_overflow", {63'd0, ovf_a}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
